// File: rtl/sand_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sand_sweep_ctrl
// Description : Runs one falling-sand physics step per frame tick. It sweeps
//               row pairs from the bottom up through a shared framebuffer RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module sand_sweep_ctrl #(
    parameter int WORDS_PER_ROW = 40,
    parameter int NUM_ROWS      = 480,
    parameter int ADDR_W        = 15,
    parameter int SPOUT_WORD    = 20
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              frame_tick,
    input  logic              spout_en,
    input  logic              mem_gnt,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       region,
    output logic [31:0]       floor,
    output logic              screenbegin,
    output logic              screenend,
    output logic              screenbottom,
    output logic              spout,
    input  logic [31:0]       new_region,
    input  logic [31:0]       new_floor,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam int c_RW = $clog2(NUM_ROWS);
    localparam int c_WW = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
    localparam logic [c_RW-1:0]   c_TOP_ROW   = c_RW'(NUM_ROWS - 2);
    localparam logic [c_WW-1:0]   c_LAST_WORD = c_WW'(WORDS_PER_ROW - 1);
    localparam logic [ADDR_W-1:0] c_WPR       = ADDR_W'(WORDS_PER_ROW);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_REG = 3'd1,
        S_RD_FLR = 3'd2,
        S_CAP    = 3'd3,
        S_WR_REG = 3'd4,
        S_WR_FLR = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [c_RW-1:0]   r_row;
    logic [c_WW-1:0]   r_word;
    logic              r_pending;
    logic              r_overrun;
    logic              r_cap_region;
    logic [31:0]       r_region;
    logic [31:0]       r_floor;
    logic [3:0]        r_flags;
    logic              w_start;
    logic              w_adv_word;
    logic              w_adv_row;
    logic [ADDR_W-1:0] w_reg_addr;
    logic [ADDR_W-1:0] w_flr_addr;

    assign w_reg_addr = ADDR_W'(r_row) * c_WPR + ADDR_W'(r_word);
    assign w_flr_addr = w_reg_addr + c_WPR;

    always_comb begin
        w_next     = r_state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        w_start    = 1'b0;
        w_adv_word = 1'b0;
        w_adv_row  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (frame_tick || r_pending) begin
                    w_start = 1'b1;
                    w_next  = S_RD_REG;
                end
            end
            S_RD_REG: begin
                mem_req  = 1'b1;
                mem_addr = w_reg_addr;
                if (mem_gnt) w_next = S_RD_FLR;
            end
            S_RD_FLR: begin
                mem_req  = 1'b1;
                mem_addr = w_flr_addr;
                if (mem_gnt) w_next = S_CAP;
            end
            S_CAP: w_next = S_WR_REG;
            S_WR_REG: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = w_reg_addr;
                mem_wdata = new_region;
                if (mem_gnt) w_next = S_WR_FLR;
            end
            S_WR_FLR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = w_flr_addr;
                mem_wdata = new_floor;
                if (mem_gnt) begin
                    if (r_word != c_LAST_WORD) begin
                        w_adv_word = 1'b1;
                        w_next     = S_RD_REG;
                    end else if (r_row != '0) begin
                        w_adv_row = 1'b1;
                        w_next    = S_RD_REG;
                    end else begin
                        w_next = S_DONE;
                    end
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_row        <= c_TOP_ROW;
            r_word       <= '0;
            r_pending    <= 1'b0;
            r_overrun    <= 1'b0;
            r_cap_region <= 1'b0;
            r_region     <= '0;
            r_floor      <= '0;
            r_flags      <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_row  <= c_TOP_ROW;
                r_word <= '0;
            end else if (w_adv_word) begin
                r_word <= r_word + c_WW'(1);
            end else if (w_adv_row) begin
                r_word <= '0;
                r_row  <= r_row - c_RW'(1);
            end
            // A tick in the DONE cycle still counts as busy and queues a step.
            if (r_state == S_IDLE) begin
                if (w_start) r_pending <= 1'b0;
            end else if (frame_tick) begin
                if (!r_pending) r_pending <= 1'b1;
                else            r_overrun <= 1'b1;
            end
            // Region is captured only in the cycle right after its granted read.
            r_cap_region <= (r_state == S_RD_REG) && mem_gnt;
            if (r_cap_region)      r_region <= mem_rdata;
            if (r_state == S_CAP)  r_floor  <= mem_rdata;
            if (r_state == S_IDLE) begin
                r_flags <= '0;
            end else begin
                r_flags <= {r_word == '0,
                            r_word == c_LAST_WORD,
                            r_row == c_TOP_ROW,
                            spout_en && (r_row == '0) && (int'(r_word) == SPOUT_WORD)};
            end
        end
    end

    assign region       = r_region;
    assign floor        = r_floor;
    assign screenbegin  = r_flags[3];
    assign screenend    = r_flags[2];
    assign screenbottom = r_flags[1];
    assign spout        = r_flags[0];
    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_DONE);
    assign overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sand_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sand_sweep_ctrl
// Description : Scoreboard bench for sand_sweep_ctrl with a RAM and datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sand_sweep_ctrl;

    localparam int W  = 2;
    localparam int N  = 3;
    localparam int AW = 4;
    localparam int SP = 1;
    localparam int NW = W * N;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          frame_tick = 1'b0;
    logic          spout_en = 1'b0;
    logic          mem_gnt = 1'b1;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic [31:0]   region, floor, new_region, new_floor;
    logic          screenbegin, screenend, screenbottom, spout;
    logic          busy, done, overrun;

    int            dp_mode = 0;
    int            gnt_mode = 0;
    int            checks = 0;
    int            passes = 0;
    int            done_cnt = 0;
    int            cyc = 0;
    logic          do_load = 1'b0;
    logic [31:0]   ram [16];
    logic [31:0]   pre [16];
    logic [31:0]   mdl [16];

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [31:0]   data;
        logic          fchk;
        logic [3:0]    flags;
        logic [31:0]   rv;
        logic [31:0]   fv;
    } txn_t;
    txn_t sb[$];

    sand_sweep_ctrl #(.WORDS_PER_ROW(W), .NUM_ROWS(N), .ADDR_W(AW), .SPOUT_WORD(SP)) dut (
        .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .spout_en(spout_en),
        .mem_gnt(mem_gnt), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .region(region), .floor(floor),
        .screenbegin(screenbegin), .screenend(screenend), .screenbottom(screenbottom),
        .spout(spout), .new_region(new_region), .new_floor(new_floor),
        .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] dp(input int mode, input logic [31:0] r, input logic [31:0] f);
        case (mode)
            0:       dp = {r, f};
            1:       dp = {32'hAAAA_AAAA, 32'h5555_5555};
            default: dp = {r ^ {f[15:0], f[31:16]}, f + r};
        endcase
    endfunction

    assign {new_region, new_floor} = dp(dp_mode, region, floor);

    // Framebuffer RAM: read data is only meaningful the cycle after a granted read.
    always @(posedge clk) begin
        if (do_load) begin
            for (int i = 0; i < 16; i++) ram[i] <= pre[i];
        end else if (mem_req && mem_gnt) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end else begin
            mem_rdata <= $urandom;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            case (gnt_mode)
                0:       mem_gnt = 1'b1;
                1:       mem_gnt = ~mem_gnt;
                default: mem_gnt = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    endtask

    // Monitor: every granted RAM access must match the next expected transaction.
    initial begin
        txn_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!reset_n) begin
                cyc = 0;
            end else begin
                if (mem_req && mem_gnt) begin
                    if (sb.size() == 0) begin
                        chk(1'b0, "unexpected_txn", 32'({mem_we, mem_addr}), 32'hFFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        chk(mem_addr == e.addr && mem_we == e.we, "txn_we_addr",
                            32'({mem_we, mem_addr}), 32'({e.we, e.addr}));
                        if (e.we) chk(mem_wdata == e.data, "txn_wdata", mem_wdata, e.data);
                        if (e.fchk) begin
                            chk(region == e.rv, "region", region, e.rv);
                            chk(floor == e.fv, "floor", floor, e.fv);
                            chk({screenbegin, screenend, screenbottom, spout} == e.flags, "flags",
                                32'({screenbegin, screenend, screenbottom, spout}), 32'(e.flags));
                        end
                    end
                end
                if (busy) cyc++;
                if (done) begin
                    done_cnt++;
                    if (gnt_mode == 0) chk(cyc == 5 * W * (N - 1) + 1, "sweep_cycles", cyc, 5 * W * (N - 1) + 1);
                    cyc = 0;
                end
            end
        end
    end

    // Reference sweep: bottom-up row pairs, left to right, applying the datapath.
    task automatic model_sweep(input int limit);
        int n = 0;
        for (int r = N - 2; r >= 0; r--) begin
            for (int w = 0; w < W; w++) begin
                int a0 = r * W + w;
                int a1 = (r + 1) * W + w;
                logic [31:0] rv = mdl[a0];
                logic [31:0] fv = mdl[a1];
                logic [63:0] nv = dp(dp_mode, rv, fv);
                logic [3:0] fl = {w == 0, w == W - 1, r == N - 2, spout_en && r == 0 && w == SP};
                if (n < limit) begin sb.push_back('{AW'(a0), 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0}); n++; end
                if (n < limit) begin sb.push_back('{AW'(a1), 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0}); n++; end
                if (n < limit) begin
                    sb.push_back('{AW'(a0), 1'b1, nv[63:32], 1'b1, fl, rv, fv});
                    mdl[a0] = nv[63:32];
                    n++;
                end
                if (n < limit) begin
                    sb.push_back('{AW'(a1), 1'b1, nv[31:0], 1'b0, 4'h0, 32'h0, 32'h0});
                    mdl[a1] = nv[31:0];
                    n++;
                end
            end
        end
    endtask

    task automatic preload();
        for (int i = 0; i < 16; i++) begin
            pre[i] = $urandom;
            mdl[i] = pre[i];
        end
        @(negedge clk) do_load = 1'b1;
        @(negedge clk) do_load = 1'b0;
    endtask

    task automatic pulse_tick();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int t = 0;
        while (done_cnt < target && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk(done_cnt >= target, "done_timeout", done_cnt, target);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_ram();
        for (int i = 0; i < NW; i++) chk(ram[i] == mdl[i], "ram_word", ram[i], mdl[i]);
        chk(sb.size() == 0, "sb_empty", sb.size(), 0);
    endtask

    task automatic run_sweep(input int mode, input int gmode, input logic sen);
        int base;
        dp_mode = mode;
        gnt_mode = gmode;
        spout_en = sen;
        preload();
        model_sweep(1000);
        base = done_cnt;
        pulse_tick();
        wait_done(base + 1);
        check_ram();
    endtask

    initial begin
        int base, t;
        repeat (3) @(negedge clk);
        chk(mem_req == 1'b0, "rst_mem_req", 32'(mem_req), 0);
        chk(busy == 1'b0 && done == 1'b0, "rst_busy_done", 32'({busy, done}), 0);
        chk(overrun == 1'b0, "rst_overrun", 32'(overrun), 0);
        chk(region == 32'h0 && floor == 32'h0, "rst_region_floor", region | floor, 0);
        chk({screenbegin, screenend, screenbottom, spout} == 4'h0, "rst_flags",
            32'({screenbegin, screenend, screenbottom, spout}), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        run_sweep(0, 0, 1'b1);
        run_sweep(1, 0, 1'b1);
        chk(ram[0] == 32'hAAAA_AAAA && ram[1] == 32'hAAAA_AAAA, "const_row0", ram[0], 32'hAAAA_AAAA);
        chk(ram[2] == 32'h5555_5555 && ram[5] == 32'h5555_5555, "const_rows12", ram[2], 32'h5555_5555);
        run_sweep(2, 1, 1'b0);
        run_sweep(0, 1, 1'b1);
        run_sweep(2, 2, 1'b1);

        // Back-to-back ticks: one queued step, the rest flagged as overrun.
        dp_mode = 2;
        gnt_mode = 0;
        spout_en = 1'b1;
        preload();
        chk(overrun == 1'b0, "overrun_pre", 32'(overrun), 0);
        model_sweep(1000);
        model_sweep(1000);
        base = done_cnt;
        pulse_tick();
        repeat (3) begin
            repeat (2) @(negedge clk);
            pulse_tick();
        end
        wait_done(base + 2);
        repeat (40) @(negedge clk);
        chk(done_cnt == base + 2, "extra_sweeps", done_cnt - base, 2);
        chk(busy == 1'b0, "busy_after", 32'(busy), 0);
        chk(overrun == 1'b1, "overrun_set", 32'(overrun), 1);
        check_ram();

        // Abort in the region write of the fourth word.
        preload();
        model_sweep(14);
        base = done_cnt;
        pulse_tick();
        t = 0;
        while (!(mem_req && mem_we && mem_addr == AW'(0)) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk(t < 200, "abort_trigger", t, 200);
        repeat (5) @(negedge clk);
        chk(mem_req && mem_we && mem_addr == AW'(1), "abort_point", 32'({mem_we, mem_addr}), 32'h11);
        reset_n = 1'b0;
        #1;
        chk(mem_req == 1'b0 && busy == 1'b0, "abort_outputs", 32'({mem_req, busy}), 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        chk(done_cnt == base && busy == 1'b0, "abort_no_done", done_cnt - base, 0);
        chk(overrun == 1'b0, "abort_overrun_clr", 32'(overrun), 0);
        check_ram();
        model_sweep(1000);
        base = done_cnt;
        pulse_tick();
        t = 0;
        while (!mem_req && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk(mem_req && !mem_we && mem_addr == AW'((N - 2) * W), "restart_addr",
            32'(mem_addr), (N - 2) * W);
        wait_done(base + 1);
        check_ram();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
